// File: rtl/queen_backtrack_ctrl.sv
// Backtracking N-queens search controller for an 8x8 board held as one-hot columns.
// Solutions are offered over valid/ready and counted; decoder8to3 recovers row indices.

module decoder8to3 (
  input  logic [7:0] onehot,
  output logic [2:0] idx
);
  always_comb begin
    // NOTE: default assignment first, so every path assigns idx and no latch is inferred.
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (onehot[i]) idx = 3'(i);
  end
endmodule

module queen_backtrack_ctrl #(
  parameter int N             = 8,
  parameter bit STOP_AT_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sol_ready,
  input  logic [$clog2(N)-1:0] rd_col,
  output logic                 busy,
  output logic                 done,
  output logic                 sol_valid,
  output logic [6:0]           sol_count,
  output logic [N*N-1:0]       board,
  output logic [$clog2(N)-1:0] rd_row
);
  localparam int W = $clog2(N);

  typedef enum logic [2:0] {IDLE, CHECK, BACKTRACK, SOLVED, FINISH} state_t;

  state_t       state;
  logic [W-1:0] c;
  logic [W-1:0] r;
  logic [W-1:0] c_prev;
  logic [W-1:0] row [N];
  logic         conflict;

  for (genvar g = 0; g < N; g++) begin : g_dec
    decoder8to3 u_dec (.onehot(board[N*g +: N]), .idx(row[g]));
  end

  decoder8to3 u_rd (.onehot(board[N*rd_col +: N]), .idx(rd_row));

  assign c_prev = c - W'(1);

  // Only already-placed columns (j < c) can attack the candidate square.
  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (W'(j) < c) begin
        if (row[j] == r) conflict = 1'b1;
        if (((r > row[j]) ? (r - row[j]) : (row[j] - r)) == (c - W'(j))) conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments; the board is reset too,
    // since an aborted search must never leave a partial placement visible.
    if (rst) begin
      state     <= IDLE;
      board     <= '0;
      c         <= '0;
      r         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sol_valid <= 1'b0;
      sol_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            board     <= '0;
            sol_count <= '0;
            c         <= '0;
            r         <= '0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (!conflict) begin
            board[N*c +: N] <= N'(1) << r;
            if (c == W'(N-1)) begin
              sol_valid <= 1'b1;
              state     <= SOLVED;
            end else begin
              c <= c + W'(1);
              r <= '0;
            end
          end else if (r != W'(N-1)) begin
            r <= r + W'(1);
          end else begin
            state <= BACKTRACK;
          end
        end
        BACKTRACK: begin
          if (c == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            // Column c is still empty here; resume the previous column one row lower.
            board[N*c_prev +: N] <= '0;
            c     <= c_prev;
            r     <= row[c_prev] + W'(1);
            state <= (row[c_prev] == W'(N-1)) ? BACKTRACK : CHECK;
          end
        end
        SOLVED: begin
          if (sol_valid && sol_ready) begin
            sol_valid <= 1'b0;
            if (sol_count != '1) sol_count <= sol_count + 7'd1;
            if (STOP_AT_FIRST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              board[N*(N-1) +: N] <= '0;
              r     <= row[N-1] + W'(1);
              state <= (row[N-1] == W'(N-1)) ? BACKTRACK : CHECK;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/queen_backtrack_ctrl.md
Name: queen_backtrack_ctrl

Overview:
- Sequences an exhaustive backtracking search for all N-queens placements on an 8x8 board.
- The board is held as eight one-hot column registers, the same format the column-to-row decoder consumes.
- Each solution is presented through a valid/ready handshake, and a running solution count is kept.
- Sits between the top-level start/readout logic and the board decode path. Reuses decoder8to3 for readout and for recovering rows during backtrack.

Parameters:
- N, 8: board dimension. Only 8 is supported; widths are derived from it.
- STOP_AT_FIRST, 0: if 1, the search ends after the first accepted solution.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin search; sampled only in IDLE
- sol_ready  input  1  consumer accepts the presented solution
- rd_col  input  3  column select for readout
- busy  output  1  high from the cycle after start acceptance until DONE
- done  output  1  one-cycle pulse when the search terminates
- sol_valid  output  1  board holds a complete solution; held until sol_ready
- sol_count  output  7  number of solutions accepted so far
- board  output  64  column c occupies bits [8c+7:8c], one-hot row; all zeros = empty
- rd_row  output  3  row index of board column rd_col, via decoder8to3 (empty column gives 0)

Behaviour:
- Reset: state=IDLE; board=0; c=0; r=0; busy=0; done=0; sol_valid=0; sol_count=0.
- Reset in any state aborts the search immediately with the same values. No partial solution is reported.
- States: IDLE, CHECK, BACKTRACK, SOLVED, FINISH.
- IDLE: start=1 clears board and sol_count and sets c=0, r=0; the next state is CHECK. Outputs and count hold otherwise, so the final count stays readable after done.
- CHECK (one cycle per candidate): candidate (c,r) conflicts if, for any j<c, row_j==r or |r-row_j|==c-j. Use unsigned 3-bit abs-difference compares; columns j>=c are ignored.
  - Safe: board[c] <= 1<<r. If c==7 go to SOLVED; else c<=c+1, r<=0, stay in CHECK.
  - Conflict with r<7: r<=r+1.
  - Conflict with r==7: go to BACKTRACK.
- BACKTRACK (one cycle):
  - If c==0, go to FINISH.
  - Else clear board[c-1], c<=c-1, r<=decode(board[c-1])+1.
  - If the decoded row is 7, stay in BACKTRACK; otherwise go to CHECK.
  - board[c] is already zero here because column c was never written.
- SOLVED: sol_valid=1 and board is stable. Move on in the cycle where sol_valid and sol_ready are both high:
  - sol_count increments.
  - If STOP_AT_FIRST is set, go to FINISH.
  - Otherwise clear board[7], set r<=row_7+1, c=7; go to CHECK, or to BACKTRACK if row_7==7.
- sol_valid drops the cycle after acceptance. sol_ready while not in SOLVED is ignored.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. The board keeps its last contents: zeros after an exhaustive search, the solution after a STOP_AT_FIRST stop.
- start during busy is ignored.
- Search order is column-major, rows ascending, so the solution sequence is deterministic.
- sol_count saturates at 127 (never reached for N=8; total is 92).
- rd_row is purely combinational from board and rd_col, valid in every state.

Test Plan:
- Reset then start with sol_ready tied 1 -> first sol_valid board rows (col0..7) = 0,4,7,5,2,6,1,3. done pulses once; final sol_count=92; board=0 after done.
- Last solution check -> 92nd presented board rows = 7,3,0,2,5,1,6,4; no sol_valid after it.
- Backpressure: sol_ready held 0 for 20 cycles on the first solution -> sol_valid and board stable for all 20 cycles, sol_count stays 0. Raising sol_ready gives count 1 next cycle and the search resumes.
- STOP_AT_FIRST=1 -> exactly one solution; sol_count=1; done pulses; board retains 0,4,7,5,2,6,1,3; rd_col=2 gives rd_row=7.
- Assert rst mid-search (e.g. 500 cycles after start) -> next cycle busy=0, board=0, sol_count=0, state IDLE. A new start then reproduces the first-solution board.
- start pulsed while busy and while sol_valid is pending -> no effect on search order or count. start in IDLE after done -> sol_count restarts from 0.
